// File: rtl/alu_result_wb_if.sv
// Handshake bundle between the ALU, the writeback buffer and the register-file write port.
// The slave modport is the buffer's view; the master modport is the surrounding datapath.
interface alu_result_wb_if #(
    parameter int DATA_BITS     = 8,
    parameter int REG_ADDR_BITS = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_BITS-1:0]     in_result;
    logic [1:0]               in_op;
    logic [DATA_BITS-1:0]     in_rt;
    logic [REG_ADDR_BITS-1:0] in_rd;
    logic                     in_cmp;

    logic                     wb_valid;
    logic                     wb_ready;
    logic [REG_ADDR_BITS-1:0] wb_rd;
    logic [DATA_BITS-1:0]     wb_data;

    modport slave (
        input  in_valid, in_result, in_op, in_rt, in_rd, in_cmp, wb_ready,
        output in_ready, wb_valid, wb_rd, wb_data
    );

    modport master (
        output in_valid, in_result, in_op, in_rt, in_rd, in_cmp, wb_ready,
        input  in_ready, wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/alu_result_wb.sv
// Writeback buffer behind the 8-bit ALU: a small show-ahead FIFO that drains register writes,
// retires compare results into the NZP flags, flags divide-by-zero and drops read-only writes.
module alu_result_wb #(
    parameter int DATA_BITS     = 8,
    parameter int REG_ADDR_BITS = 4,
    parameter int DEPTH         = 4,
    parameter int RO_BASE       = 13
) (
    input  logic                   clk,
    input  logic                   reset,
    alu_result_wb_if.slave         bus,
    output logic [2:0]             nzp_out,
    output logic                   err_div0,
    output logic [7:0]             dropped,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int OCC_BITS = PTR_BITS + 1;
    localparam logic [OCC_BITS-1:0]      FULL_COUNT = OCC_BITS'(DEPTH);
    localparam logic [REG_ADDR_BITS-1:0] RO_FIRST   = REG_ADDR_BITS'(RO_BASE);

    logic [DATA_BITS-1:0]     mem_data [DEPTH];
    logic [REG_ADDR_BITS-1:0] mem_rd   [DEPTH];
    logic                     mem_cmp  [DEPTH];

    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;

    logic                 push_fire;
    logic                 div_zero;
    logic                 ro_target;
    logic                 store;
    logic                 pop;
    logic                 empty;
    logic [DATA_BITS-1:0] push_data;
    logic [DATA_BITS-1:0] head_data;
    logic                 head_cmp;

    // Full/empty come only from the registered count, so in_ready has no path from in_valid or wb_ready.
    assign empty        = (occupancy == '0);
    assign bus.in_ready = (occupancy != FULL_COUNT);

    assign push_fire = bus.in_valid && bus.in_ready;
    assign div_zero  = (bus.in_op == 2'b11) && (bus.in_rt == '0);
    assign ro_target = !bus.in_cmp && (bus.in_rd >= RO_FIRST);
    assign store     = push_fire && !ro_target;
    assign push_data = div_zero ? '1 : bus.in_result;

    assign head_data = mem_data[rd_ptr];
    assign head_cmp  = mem_cmp[rd_ptr];

    // Compare entries retire on their own; write entries wait for the register-file port.
    assign pop = !empty && (head_cmp || bus.wb_ready);

    always_comb begin
        bus.wb_valid = 1'b0;
        bus.wb_rd    = '0;
        bus.wb_data  = '0;
        if (!empty && !head_cmp) begin
            bus.wb_valid = 1'b1;
            bus.wb_rd    = mem_rd[rd_ptr];
            bus.wb_data  = head_data;
        end
    end

    // NOTE: the storage array carries no reset; the count and pointers define which slots are live.
    always_ff @(posedge clk) begin
        if (store) begin
            mem_data[wr_ptr] <= push_data;
            mem_rd[wr_ptr]   <= bus.in_rd;
            mem_cmp[wr_ptr]  <= bus.in_cmp;
        end
    end

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            nzp_out   <= 3'b000;
            err_div0  <= 1'b0;
            dropped   <= 8'd0;
        end else begin
            if (store) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;

            case ({store, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase

            if (pop && head_cmp) begin
                nzp_out <= {head_data[DATA_BITS-1],
                            head_data == '0,
                            !head_data[DATA_BITS-1] && (head_data != '0)};
            end

            if (push_fire && div_zero) err_div0 <= 1'b1;

            if (push_fire && ro_target && (dropped != 8'hFF)) dropped <= dropped + 8'd1;
        end
    end
endmodule

// File: doc/alu_result_wb.md
Name: alu_result_wb

Overview:
- Writeback buffer directly downstream of the 8-bit ALU.
- Accepts each ALU result with its destination register and opcode context, then queues it in a small FIFO.
- Drains entries to the register-file write port using a valid/ready handshake.
- Handles CMP-style results by updating the NZP flag register instead of writing a register.
- Detects divide-by-zero and blocks writes to read-only registers.

Parameters:
- DATA_BITS, 8, width of the ALU result and the rt operand.
- REG_ADDR_BITS, 4, width of the destination register index.
- DEPTH, 4, number of FIFO entries; must be a power of two and at least 2.
- RO_BASE, 13, lowest read-only register index; indices RO_BASE and above are never written.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream result is valid this cycle.
- in_ready  output  1  buffer can accept an entry.
- in_result  input  DATA_BITS  ALU output.
- in_op  input  2  ALU opcode: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
- in_rt  input  DATA_BITS  rt operand, used for divide-by-zero detection.
- in_rd  input  REG_ADDR_BITS  destination register.
- in_cmp  input  1  result is a compare; updates NZP only.
- wb_valid  output  1  register-file write request.
- wb_ready  input  1  register-file write port accepts the request.
- wb_rd  output  REG_ADDR_BITS  write address.
- wb_data  output  DATA_BITS  write data.
- nzp_out  output  3  {N,Z,P} flag register.
- err_div0  output  1  sticky divide-by-zero flag.
- dropped  output  8  saturating count of writes discarded because they targeted read-only registers.
- occupancy  output  clog2(DEPTH)+1  current number of FIFO entries.

Behaviour:
- Reset (asynchronous, active-high):
  - FIFO empty; pointers 0.
  - wb_valid=0, wb_rd=0, wb_data=0, nzp_out=3'b000, err_div0=0, dropped=0, occupancy=0.
  - in_ready goes to 1 once reset is released.
  - Reset mid-operation discards all queued entries; nothing is written afterwards.
- Accept rule: an entry is accepted on a rising edge where in_valid && in_ready. in_ready = (occupancy != DEPTH), combinational from registered state only.
- Push transform, applied at accept:
  - If in_op==11 and in_rt==0: the stored data is forced to all-ones and err_div0 is set (sticky until reset).
  - If in_cmp==0 and in_rd >= RO_BASE: the entry is not stored; dropped increments and saturates at 255. in_ready still asserts as normal.
  - Otherwise the entry {data, rd, cmp} is written at the tail.
- FIFO is show-ahead: the head entry drives the outputs combinationally from storage.
- Head is a write entry (cmp=0):
  - wb_valid=1, wb_rd=head.rd, wb_data=head.data.
  - The entry pops on a rising edge with wb_ready=1.
  - wb_rd and wb_data stay stable while wb_valid=1 and wb_ready=0.
- Head is a compare entry (cmp=1):
  - wb_valid=0.
  - The entry pops unconditionally on the next rising edge.
  - nzp_out is updated on that edge to {data[MSB], data==0, !data[MSB] && data!=0}.
- Pop rate: at most one entry per cycle.
- Simultaneous push and pop:
  - Allowed whenever not full; occupancy is unchanged.
  - When full, in_ready=0, so a same-cycle pop does not admit a push. New data is accepted the following cycle.
- Pointer wrap-around is modulo DEPTH. Full and empty are derived from the occupancy counter.
- Latency: an accepted entry into an empty buffer appears on wb_valid (or updates nzp_out) one cycle after the accepting edge.
- No combinational path exists from in_valid to in_ready, or from wb_ready to in_ready.

Test Plan:
- Reset, then push ADD result 0x2A to rd=3, with wb_ready=1 -> wb_valid=1, wb_rd=3, wb_data=0x2A one cycle later; occupancy returns to 0 afterwards.
- Hold wb_ready=0 and push 5 entries (DEPTH=4) -> in_ready=0 after the 4th accept and the 5th is held upstream. Release wb_ready -> entries drain in order, in_ready=1 one cycle after the first pop, and the 5th is then accepted.
- Push in_op=11, in_rt=0, in_result=0x00, rd=2 -> wb_data=0xFF and err_div0=1. err_div0 stays 1 through later entries until reset.
- Push cmp entries with data 0xF0, then 0x00, then 0x05 -> nzp_out steps through 3'b100, 3'b010, 3'b001; wb_valid never asserts.
- Push a write to rd=14, then a write to rd=1 with value 0x11 -> only rd=1 is written, and dropped=1.
- Assert reset while 3 entries are queued and wb_ready=0 -> occupancy=0 and wb_valid=0 immediately; no stale write appears after reset is released.
